// File: rtl/scan_code_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefix sequences into key events and
// queues them in a small show-ahead FIFO for a ready/valid consumer.
module scan_code_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       FCLK,
    input  logic       RST_N,
    input  logic [7:0] SCAN_CODE,
    input  logic       SCAN_VALID,
    input  logic       PARITY_OK,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       KEY_RELEASE,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic       OVERFLOW,
    input  logic       OVF_CLEAR,
    output logic [7:0] PARITY_ERR_CNT
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          push_req, push_ext, push_rel;
    logic          full, push, pop;
    logic [9:0]    head;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        push_req = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        if (SCAN_VALID) begin
            tmo_d = '0;
            if (!PARITY_OK) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        case (SCAN_CODE)
                            8'hE0: state_d = EXT;
                            8'hF0: state_d = BRK;
                            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: state_d = IDLE;
                            default: push_req = 1'b1;
                        endcase
                    end
                    EXT: begin
                        if (SCAN_CODE == 8'hF0) begin
                            state_d = EXT_BRK;
                        end else if (SCAN_CODE != 8'hE0) begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_d = IDLE;
                        if (SCAN_CODE != 8'hE0 && SCAN_CODE != 8'hF0) begin
                            push_req = 1'b1;
                            push_ext = (state_q == EXT_BRK);
                            push_rel = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            // A stalled prefix is abandoned so a lost final byte cannot corrupt the next key.
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign pop   = KEY_VALID && KEY_READY;
    assign push  = push_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        else if (pop && !push) count_d = count_q - (AW + 1)'(1);
        perr_d = perr_q;
        if (SCAN_VALID && !PARITY_OK && perr_q != 8'hFF) perr_d = perr_q + 8'd1;
        ovf_d = ovf_q;
        if (push_req && !push) ovf_d = 1'b1;
        else if (OVF_CLEAR) ovf_d = 1'b0;
    end

    always_ff @(posedge FCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            perr_q   <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // NOTE: storage is not reset; the head fields are gated by KEY_VALID instead.
    always_ff @(posedge FCLK) begin
        if (push) mem_q[wr_ptr_q] <= {push_ext, push_rel, SCAN_CODE};
    end

    assign head           = mem_q[rd_ptr_q];
    assign KEY_VALID      = (count_q != '0);
    assign KEY_CODE       = KEY_VALID ? head[7:0] : 8'h00;
    assign KEY_RELEASE    = KEY_VALID & head[8];
    assign KEY_EXTENDED   = KEY_VALID & head[9];
    assign OVERFLOW       = ovf_q;
    assign PARITY_ERR_CNT = perr_q;

endmodule

// File: tb/tb_scan_code_decoder.sv
// Self-checking bench for scan_code_decoder: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_scan_code_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       FCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] SCAN_CODE = 8'h00;
    logic       SCAN_VALID = 1'b0;
    logic       PARITY_OK = 1'b1;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED, KEY_RELEASE, KEY_VALID;
    logic       KEY_READY = 1'b0;
    logic       OVERFLOW;
    logic       OVF_CLEAR = 1'b0;
    logic [7:0] PARITY_ERR_CNT;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: prefix flags, event queue, sticky flag, error count.
    logic [9:0] mq[$];
    bit         m_ext, m_brk, m_ovf;
    int         m_perr, m_last, cyc;

    scan_code_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .FCLK(FCLK), .RST_N(RST_N), .SCAN_CODE(SCAN_CODE), .SCAN_VALID(SCAN_VALID),
        .PARITY_OK(PARITY_OK), .KEY_CODE(KEY_CODE), .KEY_EXTENDED(KEY_EXTENDED),
        .KEY_RELEASE(KEY_RELEASE), .KEY_VALID(KEY_VALID), .KEY_READY(KEY_READY),
        .OVERFLOW(OVERFLOW), .OVF_CLEAR(OVF_CLEAR), .PARITY_ERR_CNT(PARITY_ERR_CNT)
    );

    always #5 FCLK = ~FCLK;

    function automatic logic [10:0] head_now();
        return {KEY_VALID, KEY_EXTENDED, KEY_RELEASE, KEY_CODE};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_last = cyc;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit pok,
                              output bit pr, output logic [9:0] pd);
        pr = 0; pd = '0;
        if ((m_ext || m_brk) && (cyc - m_last > TMO)) begin m_ext = 0; m_brk = 0; end
        m_last = cyc;
        if (!pok) begin
            m_ext = 0; m_brk = 0;
            if (m_perr < 255) m_perr++;
        end else if (!m_ext && !m_brk) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1})) begin
                pr = 1; pd = {2'b00, b};
            end
        end else if (m_brk) begin
            if (b != 8'hE0 && b != 8'hF0) begin pr = 1; pd = {m_ext, 1'b1, b}; end
            m_ext = 0; m_brk = 0;
        end else begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin pr = 1; pd = {2'b10, b}; m_ext = 0; end
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, and return at the next negedge.
    task automatic step(input bit v, input logic [7:0] b, input bit pok, input bit rdy, input bit clr);
        bit pr, pop, full;
        logic [9:0] pd;
        SCAN_VALID = v; SCAN_CODE = b; PARITY_OK = pok; KEY_READY = rdy; OVF_CLEAR = clr;
        cyc++;
        pr = 0; pd = '0;
        if (v) model_byte(b, pok, pr, pd);
        full = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (pr && full && !pop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pr && (!full || pop)) mq.push_back(pd);
        @(negedge FCLK);
        SCAN_VALID = 0; KEY_READY = 0; OVF_CLEAR = 0; PARITY_OK = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0, 0);
    endtask

    task automatic do_reset();
        SCAN_VALID = 0; KEY_READY = 0; OVF_CLEAR = 0;
        RST_N = 0;
        model_reset();
        @(negedge FCLK);
        RST_N = 1;
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 8'hF0, 0, 0, 0);
        step(1, 8'h1C, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h22, 1, 0, 0);
        #2 RST_N = 0;
        #1;
        n_cmp++; if (head_now() !== 11'h000) begin n_err++; $display("FAIL reset_head: got %h want 000", head_now()); end
        n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        n_cmp++; if (PARITY_ERR_CNT !== 8'd0) begin n_err++; $display("FAIL reset_perr: got %0d want 0", PARITY_ERR_CNT); end
        model_reset();
        @(negedge FCLK);
        RST_N = 1;
    endtask

    task automatic test_make_code();
        do_reset();
        step(1, 8'h1C, 1, 1, 0);
        n_cmp++; if (head_now() !== {3'b100, 8'h1C}) begin n_err++; $display("FAIL make_head: got %h want 41c", head_now()); end
        step(0, 8'h00, 1, 1, 0);
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL make_one_cycle: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_ext_break_hold();
        do_reset();
        step(1, 8'hE0, 1, 0, 0);
        step(1, 8'hF0, 1, 0, 0);
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL ext_brk_prefix: valid=%b want 0", KEY_VALID); end
        step(1, 8'h75, 1, 0, 0);
        idle(3);
        n_cmp++; if (head_now() !== {3'b111, 8'h75}) begin n_err++; $display("FAIL ext_brk_hold: got %h want 775", head_now()); end
        step(0, 8'h00, 1, 1, 0);
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL ext_brk_pop: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 8'hE0, 1, 0, 0);
        idle(TMO - 1);
        step(1, 8'h1C, 1, 0, 0);
        n_cmp++; if (head_now() !== {3'b110, 8'h1C}) begin n_err++; $display("FAIL tmo_edge: got %h want 61c", head_now()); end
        step(0, 8'h00, 1, 1, 0);
        step(1, 8'hE0, 1, 0, 0);
        idle(TMO);
        step(1, 8'h1C, 1, 0, 0);
        n_cmp++; if (head_now() !== {3'b100, 8'h1C}) begin n_err++; $display("FAIL tmo_expired: got %h want 41c", head_now()); end
        step(0, 8'h00, 1, 1, 0);
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL tmo_single: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        foreach (codes[i]) step(1, codes[i], 1, 0, 0);
        n_cmp++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
        step(1, 8'h1B, 1, 0, 1);
        n_cmp++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", OVERFLOW); end
        step(0, 8'h00, 1, 0, 1);
        n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (head_now() !== {3'b100, codes[i]}) begin n_err++; $display("FAIL ovf_order%0d: got %h want %h", i, head_now(), {3'b100, codes[i]}); end
            step(0, 8'h00, 1, 1, 0);
        end
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL ovf_drained: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_parity();
        do_reset();
        step(1, 8'hF0, 0, 0, 0);
        step(1, 8'h1C, 1, 0, 0);
        n_cmp++; if (PARITY_ERR_CNT !== 8'd1) begin n_err++; $display("FAIL perr_one: got %0d want 1", PARITY_ERR_CNT); end
        n_cmp++; if (head_now() !== {3'b100, 8'h1C}) begin n_err++; $display("FAIL perr_make: got %h want 41c", head_now()); end
        step(0, 8'h00, 1, 1, 0);
        for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0, 0, 0);
        n_cmp++; if (PARITY_ERR_CNT !== 8'd255) begin n_err++; $display("FAIL perr_sat: got %0d want 255", PARITY_ERR_CNT); end
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL perr_nopush: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [4] = '{8'h32, 8'h21, 8'h23, 8'h2B};
        do_reset();
        step(1, 8'h1C, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, want[i], 1, 0, 0);
        step(1, 8'h2B, 1, 1, 0);
        n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL full_pushpop_ovf: got %b want 0", OVERFLOW); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (head_now() !== {3'b100, want[i]}) begin n_err++; $display("FAIL full_pushpop%0d: got %h want %h", i, head_now(), {3'b100, want[i]}); end
            step(0, 8'h00, 1, 1, 0);
        end
        n_cmp++; if (KEY_VALID !== 1'b0) begin n_err++; $display("FAIL full_pushpop_occ: valid=%b want 0", KEY_VALID); end
    endtask

    task automatic test_reset_mid_seq();
        do_reset();
        step(1, 8'hF0, 1, 0, 0);
        do_reset();
        step(1, 8'h1C, 1, 0, 0);
        n_cmp++; if (head_now() !== {3'b100, 8'h1C}) begin n_err++; $display("FAIL rst_mid_brk: got %h want 41c", head_now()); end
        step(1, 8'hE0, 1, 1, 0);
        do_reset();
        step(1, 8'h74, 1, 0, 0);
        n_cmp++; if (head_now() !== {3'b100, 8'h74}) begin n_err++; $display("FAIL rst_mid_ext: got %h want 474", head_now()); end
    endtask

    task automatic test_random();
        logic [7:0] noise [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
        logic [7:0] b;
        logic [10:0] exp_head;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = noise[$urandom_range(0, 6)];
                default: b = 8'($urandom);
            endcase
            step($urandom_range(0, 2) != 0, b, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
            exp_head = (mq.size() > 0) ? {1'b1, mq[0]} : 11'h000;
            n_cmp++; if (head_now() !== exp_head) begin n_err++; $display("FAIL rand_head@%0d: got %h want %h", i, head_now(), exp_head); end
            n_cmp++; if (OVERFLOW !== m_ovf) begin n_err++; $display("FAIL rand_ovf@%0d: got %b want %b", i, OVERFLOW, m_ovf); end
            n_cmp++; if (PARITY_ERR_CNT !== 8'(m_perr)) begin n_err++; $display("FAIL rand_perr@%0d: got %0d want %0d", i, PARITY_ERR_CNT, m_perr); end
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        repeat (2) @(negedge FCLK);
        RST_N = 1;
        test_reset();
        test_make_code();
        test_ext_break_hold();
        test_timeout();
        test_overflow();
        test_parity();
        test_back_to_back();
        test_reset_mid_seq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_code_decoder.md
SCAN_CODE_DECODER -- requirements
Module: scan_code_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, FCLK cycles allowed between prefix and final byte (1 ms at 50 MHz).
REQ-003 SHALL have port FCLK  in  1  single system clock, rising edge; all logic in this one domain.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port SCAN_CODE  in  8  received byte from upstream PS/2 receiver.
REQ-006 SHALL have port SCAN_VALID  in  1  one-cycle strobe: SCAN_CODE/PARITY_OK valid this cycle.
REQ-007 SHALL have port PARITY_OK  in  1  1 = frame parity correct.
REQ-008 SHALL have port KEY_CODE  out  8  head-of-FIFO key code.
REQ-009 SHALL have port KEY_EXTENDED  out  1  head event was E0-prefixed.
REQ-010 SHALL have port KEY_RELEASE  out  1  head event is a break (F0-prefixed).
REQ-011 SHALL have port KEY_VALID  out  1  FIFO non-empty; head fields valid.
REQ-012 SHALL have port KEY_READY  in  1  consumer accepts head.
REQ-013 SHALL have port OVERFLOW  out  1  sticky: event dropped due to full FIFO.
REQ-014 SHALL have port OVF_CLEAR  in  1  synchronous clear of OVERFLOW.
REQ-015 SHALL have port PARITY_ERR_CNT  out  8  count of parity-failed bytes, saturating.

Function
REQ-016 Decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen); it SHALL act only on cycles with SCAN_VALID=1, except timeout.
REQ-017 On a valid byte with PARITY_OK=0, the block SHALL discard the byte, force state to IDLE, push nothing, and increment PARITY_ERR_CNT (hold at 255).
REQ-018 On a valid byte in IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF, 0xE1 -> discarded, stay IDLE; any other byte -> push {EXT=0, REL=0, code}.
REQ-019 On a valid byte in EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; other -> push {1, 0, code}, go IDLE.
REQ-020 On a valid byte in BRK: 0xE0/0xF0 -> discard, go IDLE; other -> push {0, 1, code}, go IDLE.
REQ-021 On a valid byte in EXT_BRK: 0xE0/0xF0 -> discard, go IDLE; other -> push {1, 1, code}, go IDLE.
REQ-022 The timeout counter SHALL clear on every transition and count while not in IDLE; on reaching TIMEOUT_CYCLES-1 the state SHALL return to IDLE with no push; a SCAN_VALID in that same cycle SHALL take priority over the timeout.
REQ-023 The FIFO SHALL store 10-bit entries {EXT, REL, CODE} and be show-ahead: KEY_CODE, KEY_EXTENDED and KEY_RELEASE SHALL reflect the head whenever KEY_VALID=1.
REQ-024 Push latency SHALL be one cycle: a final byte strobed in cycle n SHALL give KEY_VALID=1 in cycle n+1 when the FIFO was empty.
REQ-025 A pop SHALL occur on each rising edge with KEY_VALID=1 and KEY_READY=1; KEY_READY while empty SHALL have no effect.
REQ-026 A simultaneous push and pop SHALL be legal at any fill level, including full, and SHALL leave the occupancy unchanged.
REQ-027 A push when full without a same-cycle pop SHALL drop the new event, leave FIFO contents intact, and set OVERFLOW=1.
REQ-028 OVERFLOW SHALL stay set until OVF_CLEAR=1; if an overflow and OVF_CLEAR occur in the same cycle, set SHALL win.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-030 Head output fields SHALL hold their value while KEY_VALID=1 and KEY_READY=0.

Reset
REQ-031 RST_N=0 SHALL immediately set state to IDLE, clear the timeout counter, FIFO pointers and occupancy, and drive KEY_VALID=0, OVERFLOW=0, PARITY_ERR_CNT=0, and KEY_CODE/KEY_EXTENDED/KEY_RELEASE=0.
REQ-032 A reset asserted mid-sequence (in EXT, BRK or EXT_BRK) SHALL discard the partial event; the first byte after release SHALL be decoded from IDLE.

Verification
REQ-033 Bytes 0x1C with KEY_READY=1 -> KEY_VALID for 1 cycle, KEY_CODE=0x1C, EXT=0, REL=0, in the cycle after the strobe.
REQ-034 Bytes E0, F0, 0x75 with KEY_READY=0 -> one entry {EXT=1, REL=1, 0x75}; FIFO holds it until KEY_READY=1.
REQ-035 Byte E0, then idle for TIMEOUT_CYCLES, then 0x1C -> exactly one entry {0, 0, 0x1C}.
REQ-036 Five make codes with KEY_READY=0 and FIFO_DEPTH=4 -> first four retained in order, OVERFLOW=1; pulse OVF_CLEAR -> OVERFLOW=0.
REQ-037 F0 with PARITY_OK=0, then 0x1C -> PARITY_ERR_CNT=1, entry {0, 0, 0x1C}; 300 parity errors -> PARITY_ERR_CNT=255.
REQ-038 Full FIFO with KEY_READY=1 and a new make code in the same cycle -> occupancy stays 4, OVERFLOW stays 0; RST_N pulse after F0 -> next 0x1C decoded as a make code.
